// File: rtl/quantum_timer.sv
// Preemption quantum timer: counts execution cycles of the running process and
// raises intSig when the slice expires, holding it until the control unit acknowledges.
module quantum_timer #(
    parameter int QUANTUM = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             halt,
    input  logic             stopQnt,
    input  logic             rstQnt,
    output logic             intSig,
    output logic [CNT_W-1:0] qntCount,
    output logic [7:0]       intCount,
    output logic [1:0]       qntState
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COUNT   = 2'd1,
        FIRE    = 2'd2,
        STOPPED = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(QUANTUM - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t state;

    assign qntState = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            intSig   <= 1'b0;
            qntCount <= '0;
            intCount <= '0;
        end else if (!enable) begin
            // Scheduler off: drop everything except the preemption tally.
            state    <= IDLE;
            intSig   <= 1'b0;
            qntCount <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= COUNT;
                    qntCount <= '0;
                    intSig   <= 1'b0;
                end
                COUNT: begin
                    if (rstQnt) begin
                        qntCount <= '0;
                    end else if (halt) begin
                        qntCount <= qntCount;
                    end else if (qntCount == LAST_CNT) begin
                        state    <= FIRE;
                        qntCount <= '0;
                        intSig   <= 1'b1;
                        intCount <= intCount + 8'd1;
                    end else begin
                        qntCount <= qntCount + CNT_ONE;
                    end
                end
                FIRE: begin
                    // Request is held through halt so it can wake a halted CPU.
                    if (stopQnt) begin
                        state  <= STOPPED;
                        intSig <= 1'b0;
                    end
                end
                STOPPED: begin
                    qntCount <= '0;
                    if (rstQnt) begin
                        state <= COUNT;
                    end
                end
                default: begin
                    state    <= IDLE;
                    intSig   <= 1'b0;
                    qntCount <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_quantum_timer.sv
// Directed self-checking bench for quantum_timer with QUANTUM=8.
`timescale 1ns/1ps
module tb_quantum_timer;

    localparam int Q = 8;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic         halt;
    logic         stopQnt;
    logic         rstQnt;
    logic         intSig;
    logic [W-1:0] qntCount;
    logic [7:0]   intCount;
    logic [1:0]   qntState;

    int checks = 0;
    int errors = 0;
    int n;

    quantum_timer #(.QUANTUM(Q), .CNT_W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .halt     (halt),
        .stopQnt  (stopQnt),
        .rstQnt   (rstQnt),
        .intSig   (intSig),
        .qntCount (qntCount),
        .intCount (intCount),
        .qntState (qntState)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; halt = 1'b0; stopQnt = 1'b0; rstQnt = 1'b0;
        step(); step();
        check("rst_state", 32'(qntState), 0);
        check("rst_int", 32'(intSig), 0);
        check("rst_cnt", 32'(qntCount), 0);
        check("rst_icnt", 32'(intCount), 0);
        rst_n = 1'b1;
        step();
        check("idle_wait", 32'(qntState), 0);

        // Test 1: basic expiry
        enable = 1'b1;
        step();
        check("t1_e0_state", 32'(qntState), 1);
        check("t1_e0_cnt", 32'(qntCount), 0);
        for (int i = 1; i < Q; i++) begin
            step();
            check("t1_cnt", 32'(qntCount), 32'(i));
            check("t1_noint", 32'(intSig), 0);
        end
        step();
        check("t1_int", 32'(intSig), 1);
        check("t1_state", 32'(qntState), 2);
        check("t1_icnt", 32'(intCount), 1);
        check("t1_cnt0", 32'(qntCount), 0);

        // Halt during FIRE keeps the request
        halt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t2_fire_halt_int", 32'(intSig), 1);
            check("t2_fire_halt_state", 32'(qntState), 2);
        end
        halt = 1'b0;

        // Test 3: acknowledge and re-arm
        stopQnt = 1'b1;
        step();
        stopQnt = 1'b0;
        check("t3_ack_int", 32'(intSig), 0);
        check("t3_ack_state", 32'(qntState), 3);
        for (int i = 0; i < 20; i++) begin
            step();
            check("t3_stop_cnt", 32'(qntCount), 0);
            check("t3_stop_state", 32'(qntState), 3);
        end
        rstQnt = 1'b1;
        step();
        rstQnt = 1'b0;
        check("t3_rearm_state", 32'(qntState), 1);
        check("t3_rearm_cnt", 32'(qntCount), 0);
        for (int i = 1; i < Q; i++) begin
            step();
            check("t3_noint", 32'(intSig), 0);
        end
        step();
        check("t3_int", 32'(intSig), 1);
        check("t3_icnt", 32'(intCount), 2);

        // Test 4a: simultaneous stop and restart in FIRE
        stopQnt = 1'b1; rstQnt = 1'b1;
        step();
        stopQnt = 1'b0; rstQnt = 1'b0;
        check("t4_simul_state", 32'(qntState), 3);
        check("t4_simul_int", 32'(intSig), 0);
        rstQnt = 1'b1;
        step();
        rstQnt = 1'b0;
        check("t4_rearm_state", 32'(qntState), 1);

        // Test 2: halt stretch, 3 halted cycles at count 4
        for (int i = 1; i <= 4; i++) step();
        check("t2_cnt4", 32'(qntCount), 4);
        halt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t2_hold", 32'(qntCount), 4);
            check("t2_noint", 32'(intSig), 0);
        end
        halt = 1'b0;
        for (int i = 5; i < Q; i++) begin
            step();
            check("t2_cnt", 32'(qntCount), 32'(i));
        end
        check("t2_noint_e10", 32'(intSig), 0);
        step();
        check("t2_int_e11", 32'(intSig), 1);
        check("t2_icnt", 32'(intCount), 3);

        // Test 4b: early restart at count 6, with stopQnt ignored in COUNT
        stopQnt = 1'b1;
        step();
        stopQnt = 1'b0;
        rstQnt = 1'b1;
        step();
        rstQnt = 1'b0;
        stopQnt = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step();
            if (i == 3) stopQnt = 1'b0;
        end
        check("t4_cnt6", 32'(qntCount), 6);
        check("t4_state_cnt", 32'(qntState), 1);
        rstQnt = 1'b1;
        step();
        rstQnt = 1'b0;
        check("t4_restart_cnt", 32'(qntCount), 0);
        for (int i = 1; i < Q; i++) begin
            step();
            check("t4_noint", 32'(intSig), 0);
        end
        step();
        check("t4_int", 32'(intSig), 1);
        check("t4_icnt", 32'(intCount), 4);

        // Test 5: disable mid-count
        stopQnt = 1'b1;
        step();
        stopQnt = 1'b0;
        rstQnt = 1'b1;
        step();
        rstQnt = 1'b0;
        for (int i = 1; i <= 5; i++) step();
        check("t5_cnt5", 32'(qntCount), 5);
        enable = 1'b0;
        step();
        check("t5_dis_state", 32'(qntState), 0);
        check("t5_dis_cnt", 32'(qntCount), 0);
        check("t5_dis_icnt", 32'(intCount), 4);
        enable = 1'b1;
        step();
        check("t5_reen_state", 32'(qntState), 1);
        for (int i = 0; i < Q; i++) step();
        check("t5_int", 32'(intSig), 1);
        check("t5_icnt", 32'(intCount), 5);

        // Async reset between edges while intSig is high
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_arst_int", 32'(intSig), 0);
        check("t5_arst_state", 32'(qntState), 0);
        check("t5_arst_cnt", 32'(qntCount), 0);
        check("t5_arst_icnt", 32'(intCount), 0);
        enable = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("t5_post_idle", 32'(qntState), 0);
        enable = 1'b1;
        step();
        check("t5_post_count", 32'(qntState), 1);

        // Test 6: 256 quanta, intCount wraps
        for (int k = 0; k < 256; k++) begin
            n = 0;
            while (intSig !== 1'b1 && n <= 20) begin
                step();
                n++;
            end
            check("t6_len", 32'(n), Q);
            if (k == 254) check("t6_icnt255", 32'(intCount), 255);
            stopQnt = 1'b1;
            step();
            stopQnt = 1'b0;
            rstQnt = 1'b1;
            step();
            rstQnt = 1'b0;
        end
        check("t6_wrap", 32'(intCount), 0);
        check("t6_state", 32'(qntState), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/quantum_timer.md
# quantum_timer

Preemption quantum timer for the multitasking processor. Counts execution cycles of the running process and raises `intSig` to the control unit when the time slice expires. The control unit's `stopQnt` and `rstQnt` outputs are this block's inputs: `stopQnt` acknowledges the interrupt dispatch, and `rstQnt` re-arms the quantum when the OS resumes a process. The block sits beside the PC/control path, and `intSig` feeds the control decoder directly.

## Interface
Parameters:
- `QUANTUM`, default 64: slice length in counted cycles. Legal range is 2 to 2^`CNT_W`.
- `CNT_W`, default 16: width of the cycle counter.

Ports:
- `clk` input 1: the only clock. All state changes on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `enable` input 1: scheduler on. Level-sensitive.
- `halt` input 1: processor `Halt` (halt or `in` wait). Freezes counting.
- `stopQnt` input 1: interrupt-dispatch acknowledge from the control unit.
- `rstQnt` input 1: restart the quantum (OS `rstQnt` instruction).
- `intSig` output 1: preemption request. Registered.
- `qntCount` output `CNT_W`: current cycle count.
- `intCount` output 8: number of preemptions fired. Wraps at 256.
- `qntState` output 2: state code. IDLE=0, COUNT=1, FIRE=2, STOPPED=3.

## Operation
- Reset (async, `rst_n`=0):
  - state IDLE
  - `intSig`=0, `qntCount`=0, `intCount`=0, `qntState`=0
- `enable`=0 in any state:
  - next edge → IDLE, `qntCount`=0, `intSig`=0.
  - `intCount` is kept.
  - `enable`=0 overrides every other input.
- IDLE: `enable`=1 → COUNT with `qntCount`=0.
- COUNT:
  - `rstQnt`=1 → `qntCount`=0, stay in COUNT. Highest priority within COUNT.
  - Otherwise, `halt`=1 → hold `qntCount`.
  - Otherwise, if `qntCount`==`QUANTUM`-1 → FIRE, `qntCount`=0, `intSig`=1, `intCount`+1.
  - Otherwise → `qntCount`+1.
  - `stopQnt` is ignored in COUNT.
- FIRE:
  - `intSig` stays 1 until acknowledged.
  - `stopQnt`=1 → STOPPED, `intSig`=0.
  - `rstQnt` is ignored; `stopQnt` wins on simultaneous assertion.
  - `halt` does not drop the request. An interrupt must wake a halted CPU.
- STOPPED:
  - Counter holds at 0 while the OS handler runs.
  - `rstQnt`=1 → COUNT, `qntCount`=0.
  - `stopQnt` is ignored.
- Width rules:
  - `qntCount` never exceeds `QUANTUM`-1. No counter overflow is possible.
  - `intCount` wraps 255→0 silently.

## Timing
- Every output is a flop output. Only `rst_n` acts without an edge.
- Edge E0 samples `enable`=1 in IDLE. The first `intSig` is then high after edge E`QUANTUM` (with no halt or restart cycles in between).
- Each cycle with `halt`=1 in COUNT delays `intSig` by exactly 1 cycle.
- A `rstQnt` sampled at edge Ek restarts the count. `intSig` then rises `QUANTUM` edges after Ek.
- Acknowledge latency: `stopQnt` sampled at edge Ea gives `intSig`=0 after Ea (1 cycle).
- Minimum `intSig` pulse is 1 cycle (`stopQnt` already high at the first FIRE edge).
- Restart: `rstQnt` sampled at edge Er in STOPPED gives `qntState`=COUNT and `qntCount`=0 after Er.
- Reset asserted mid-FIRE: `intSig` drops immediately (asynchronously). After release, the block waits in IDLE for an edge with `enable`=1.

## Test plan
1. **Basic expiry.** `QUANTUM`=8, reset, then `enable`=1 from E0. Required: `qntCount` steps 0..7; `intSig`=1 after E8; `intCount`=1; `qntState`=2.
2. **Halt stretch.** As in test 1, plus `halt`=1 for 3 cycles at `qntCount`=4. Required: `qntCount` holds at 4; `intSig` rises after E11. Then assert `halt` during FIRE. Required: `intSig` stays 1.
3. **Acknowledge and re-arm.** In FIRE, `stopQnt`=1 for one cycle. Required: `intSig`=0 and STOPPED next cycle; `qntCount` holds at 0 for 20 idle cycles. Then `rstQnt`=1. Required: COUNT; next `intSig` 8 edges later; `intCount`=2.
4. **Simultaneous and early restart.** In FIRE, `stopQnt`=`rstQnt`=1 together. Required: STOPPED. In COUNT at `qntCount`=6, `rstQnt`=1. Required: `qntCount`=0; no `intSig` for 8 more edges.
5. **Disable and reset mid-operation.**
   - Drop `enable` at `qntCount`=5. Required: IDLE, `qntCount`=0, `intCount` kept.
   - Assert `rst_n`=0 between edges while `intSig`=1. Required: all outputs 0 immediately.
6. **Wrap.** Fire 256 quanta (each acknowledged with `stopQnt`, then re-armed with `rstQnt`). Required: `intCount` returns to 0; every expiry is still exactly `QUANTUM` edges long.
